// File: rtl/doc_uart_sender.sv
// -----------------------------------------------------------------------------
// doc_uart_sender
//
// Purpose:
//   Streams the text document RAM out of the board TX pin as UART 8N1 when a
//   send is requested. The stream is row-major text: COLS characters per row
//   followed by CR LF, for ROWS rows (ROWS*(COLS+2) bytes per send). NUL
//   characters in the document are sent as spaces. A one-cycle done pulse
//   after the final stop bit lets the editor clear its document.
//
// Parameters:
//   CLK_HZ  system clock frequency in Hz
//   BAUD    line rate; DIV = CLK_HZ/BAUD clocks per bit
//   ROWS    document rows sent (1..16)
//   COLS    characters per row sent (1..32)
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   start        in   single-cycle send request (only honoured in IDLE)
//   read_enable  out  claims the document read port for the whole send
//   read_addr    out  document address {row[3:0], col[4:0]}
//   read_data    in   document data, combinational read of read_addr
//   tx           out  UART serial output, idle high, registered
//   busy         out  high from the accepted start through the done cycle
//   done         out  one-cycle pulse after the final stop bit
//   dbg_state    out  current FSM state encoding (see state_t)
//
// Handshake: start is a fire-and-forget pulse. It is accepted only when the
// FSM is in IDLE (busy low); a pulse at any other time, including the done
// cycle, is dropped. done/busy need no acknowledgement.
// -----------------------------------------------------------------------------
module doc_uart_sender #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int ROWS   = 15,
  parameter int COLS   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       read_enable,
  output logic [8:0] read_addr,
  input  logic [7:0] read_data,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  // Clocks per bit and the width of the bit timer that counts 0..DIV-1.
  localparam int DIV     = CLK_HZ / BAUD;
  localparam int TIMER_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DIV - 1);
  localparam logic [4:0]         COL_LAST   = 5'(COLS - 1);
  localparam logic [3:0]         ROW_LAST   = 4'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START_BIT = 3'd2,
    S_DATA_BITS = 3'd3,
    S_STOP_BIT  = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  // What the current byte slot carries: a document character or a line end.
  typedef enum logic [1:0] {
    SEL_CHAR = 2'd0,
    SEL_CR   = 2'd1,
    SEL_LF   = 2'd2
  } sel_t;

  state_t               r_state;
  sel_t                 r_sel;
  logic [3:0]           r_row;
  logic [4:0]           r_col;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit_idx;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_read_enable;

  logic                 w_bit_end;
  logic [7:0]           w_char;

  // Last clock of the current bit period.
  assign w_bit_end = (r_timer == TIMER_LAST);

  // A NUL cell in the document is an empty position on screen; send a space.
  assign w_char = (read_data == 8'h00) ? 8'h20 : read_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sel         <= SEL_CHAR;
      r_row         <= 4'd0;
      r_col         <= 5'd0;
      r_shift       <= 8'd0;
      r_bit_idx     <= 3'd0;
      r_timer       <= '0;
      r_tx          <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_read_enable <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (start) begin
            r_state       <= S_LOAD;
            r_row         <= 4'd0;
            r_col         <= 5'd0;
            r_sel         <= SEL_CHAR;
            r_busy        <= 1'b1;
            r_read_enable <= 1'b1;
          end
        end

        // read_addr has been stable since NEXT, so read_data is settled here.
        S_LOAD: begin
          case (r_sel)
            SEL_CHAR: r_shift <= w_char;
            SEL_CR:   r_shift <= 8'h0D;
            default:  r_shift <= 8'h0A;
          endcase
          r_timer <= '0;
          r_tx    <= 1'b0;
          r_state <= S_START_BIT;
        end

        S_START_BIT: begin
          if (w_bit_end) begin
            r_timer   <= '0;
            r_bit_idx <= 3'd0;
            // Present bit 0 and pre-shift so r_shift[0] is always the next bit.
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_state   <= S_DATA_BITS;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_DATA_BITS: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP_BIT;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_STOP_BIT: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_state <= S_NEXT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        // Advance the text cursor. The column is left at COLS-1 while the
        // line end is sent, so the address only moves on a new character.
        S_NEXT: begin
          r_tx <= 1'b1;
          if ((r_sel == SEL_LF) && (r_row == ROW_LAST)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_LOAD;
            case (r_sel)
              SEL_CHAR: begin
                if (r_col == COL_LAST) begin
                  r_sel <= SEL_CR;
                end else begin
                  r_col <= r_col + 5'd1;
                end
              end
              SEL_CR: begin
                r_sel <= SEL_LF;
              end
              default: begin
                r_row <= r_row + 4'd1;
                r_col <= 5'd0;
                r_sel <= SEL_CHAR;
              end
            endcase
          end
        end

        // busy/read_enable stay high through this cycle, so a start pulse
        // landing here is ignored and the editor sees done while still owned.
        S_DONE: begin
          r_done        <= 1'b0;
          r_busy        <= 1'b0;
          r_read_enable <= 1'b0;
          r_tx          <= 1'b1;
          r_state       <= S_IDLE;
        end

        default: begin
          r_state       <= S_IDLE;
          r_done        <= 1'b0;
          r_busy        <= 1'b0;
          r_read_enable <= 1'b0;
          r_tx          <= 1'b1;
        end
      endcase
    end
  end

  assign read_enable = r_read_enable;
  assign read_addr   = r_read_enable ? {r_row, r_col} : 9'd0;
  assign tx          = r_tx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_doc_uart_sender.sv
// -----------------------------------------------------------------------------
// tb_doc_uart_sender
//
// Two instances: "a" uses a small document (ROWS=2, COLS=3, DIV=16) for the
// directed cases, "b" keeps the default ROWS/COLS with DIV=4 for the full
// 330-byte send. Each instance has a UART receiver process that decodes the
// tx line and compares every byte against an expected queue filled when the
// send is requested.
// -----------------------------------------------------------------------------
module tb_doc_uart_sender;

  localparam int DIV_A  = 16;
  localparam int DIV_B  = 4;
  localparam int ROWS_B = 15;
  localparam int COLS_B = 20;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUTs
  logic       start_a, re_a, tx_a, busy_a, done_a;
  logic [8:0] addr_a;
  logic [7:0] rdata_a;
  logic [2:0] st_a;
  logic       start_b, re_b, tx_b, busy_b, done_b;
  logic [8:0] addr_b;
  logic [7:0] rdata_b;
  logic [2:0] st_b;

  logic [7:0] mem_a [0:511];
  logic [7:0] mem_b [0:511];

  assign rdata_a = mem_a[addr_a];
  assign rdata_b = mem_b[addr_b];

  doc_uart_sender #(.CLK_HZ(16), .BAUD(1), .ROWS(2), .COLS(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .read_enable(re_a),
    .read_addr(addr_a), .read_data(rdata_a), .tx(tx_a), .busy(busy_a),
    .done(done_a), .dbg_state(st_a)
  );

  doc_uart_sender #(.CLK_HZ(4), .BAUD(1), .ROWS(ROWS_B), .COLS(COLS_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .read_enable(re_b),
    .read_addr(addr_b), .read_data(rdata_b), .tx(tx_b), .busy(busy_b),
    .done(done_b), .dbg_state(st_b)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q  [$];
  logic [7:0] exp_qb [$];
  logic [7:0] rx_log_a [$];
  logic [8:0] load_addr_q [$];
  logic [8:0] last_load_addr;

  int   rx_cnt_a = 0, rx_cnt_b = 0;
  int   done_cnt_a = 0, done_cnt_b = 0;
  logic mon_abort = 1'b0;
  int   s_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count every cycle done is high (pulse width and pulse count together).
  always @(negedge clk) begin
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  // Distinct addresses presented during LOAD on instance a.
  always @(negedge clk) begin
    if (st_a == 3'd1 && addr_a !== last_load_addr) begin
      load_addr_q.push_back(addr_a);
      last_load_addr <= addr_a;
    end
  end

  // ---------------------------------------------------------------- receivers
  logic [7:0] rx_a, rx_b, pop_a, pop_b;
  logic       fr_ok_a, fr_ok_b;

  initial begin : mon_a
    forever begin
      @(negedge tx_a);
      repeat (DIV_A / 2) @(posedge clk);
      #1;
      fr_ok_a = (tx_a === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV_A) @(posedge clk);
        #1;
        rx_a[i] = tx_a;
      end
      repeat (DIV_A) @(posedge clk);
      #1;
      fr_ok_a = fr_ok_a && (tx_a === 1'b1);
      if (mon_abort) begin
        mon_abort = 1'b0;
      end else begin
        rx_cnt_a++;
        rx_log_a.push_back(rx_a);
        check("frame_a", {31'd0, fr_ok_a}, 32'd1);
        check("byte_a_pending", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          pop_a = exp_q.pop_front();
          check("byte_a", {24'd0, rx_a}, {24'd0, pop_a});
        end
      end
    end
  end

  initial begin : mon_b
    forever begin
      @(negedge tx_b);
      repeat (DIV_B / 2) @(posedge clk);
      #1;
      fr_ok_b = (tx_b === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV_B) @(posedge clk);
        #1;
        rx_b[i] = tx_b;
      end
      repeat (DIV_B) @(posedge clk);
      #1;
      fr_ok_b = fr_ok_b && (tx_b === 1'b1);
      rx_cnt_b++;
      if (!fr_ok_b) check("frame_b", {31'd0, fr_ok_b}, 32'd1);
      if (exp_qb.size() == 0) begin
        check("byte_b_pending", {31'd0, exp_qb.size() != 0}, 32'd1);
      end else begin
        pop_b = exp_qb.pop_front();
        if (rx_b !== pop_b) check("byte_b", {24'd0, rx_b}, {24'd0, pop_b});
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send_a();
    logic [7:0] v;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        v = mem_a[r * 32 + c];
        exp_q.push_back((v == 8'h00) ? 8'h20 : v);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    s_cyc = cyc;
  endtask

  // Waits for done on instance a, checks the done cycle and the cycle after.
  // poke drives a start pulse into the done cycle.
  task automatic wait_done_a(input logic poke, output int lat);
    lat = -1;
    for (int k = 0; k < 5000; k++) begin
      if (done_a === 1'b1) begin
        lat = cyc - s_cyc;
        break;
      end
      tick();
    end
    check("done_a_seen", {31'd0, lat >= 0}, 32'd1);
    check("busy_at_done_a", {31'd0, busy_a}, 32'd1);
    check("re_at_done_a", {31'd0, re_a}, 32'd1);
    start_a = poke;
    tick();
    start_a = 1'b0;
    check("done_low_after_a", {31'd0, done_a}, 32'd0);
    check("busy_low_after_a", {31'd0, busy_a}, 32'd0);
    check("re_low_after_a", {31'd0, re_a}, 32'd0);
    check("tx_idle_after_a", {31'd0, tx_a}, 32'd1);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- sequence
  int         lat, cnt, bad, rx0, dn0;
  logic [7:0] bits;
  logic [8:0] exp_addr [6];

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    last_load_addr = 9'h1FF;
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 8'h2E;
      mem_b[i] = 8'($urandom_range(0, 255));
    end
    mem_a[0]  = 8'h41; mem_a[1]  = 8'h42; mem_a[2]  = 8'h43;
    mem_a[32] = 8'h78; mem_a[33] = 8'h79; mem_a[34] = 8'h7A;
    mem_b[5]  = 8'h00;
    mem_b[40] = 8'h00;
    exp_addr = '{9'd0, 9'd1, 9'd2, 9'd32, 9'd33, 9'd34};

    repeat (3) tick();
    check("rst_tx", {31'd0, tx_a}, 32'd1);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_re", {31'd0, re_a}, 32'd0);
    check("rst_addr", {23'd0, addr_a}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // ---- basic send with bit timing on the first frame
    check("idle_before_a", {31'd0, tx_a}, 32'd1);
    rx0 = rx_cnt_a; dn0 = done_cnt_a;
    send_a();
    check("busy_rise", {31'd0, busy_a}, 32'd1);
    check("re_rise", {31'd0, re_a}, 32'd1);
    for (int k = 0; k < 10 && tx_a !== 1'b0; k++) tick();
    cnt = 0;
    while (tx_a === 1'b0 && cnt < 100) begin
      cnt++;
      tick();
    end
    check("start_bit_len", cnt, 32'd16);
    bits = 8'h41;
    for (int i = 0; i < 8; i++) begin
      bad = 0;
      for (int j = 0; j < DIV_A; j++) begin
        if (tx_a !== bits[i]) bad++;
        tick();
      end
      check($sformatf("data_bit%0d_bad_cycles", i), bad, 32'd0);
    end
    bad = 0;
    for (int j = 0; j < DIV_A; j++) begin
      if (tx_a !== 1'b1) bad++;
      tick();
    end
    check("stop_bit_bad_cycles", bad, 32'd0);
    wait_done_a(1'b0, lat);
    check("done_latency_1", lat, 32'd1620);
    tick();
    check("rx_count_1", rx_cnt_a - rx0, 32'd10);
    check("done_count_1", done_cnt_a - dn0, 32'd1);
    check("exp_q_empty_1", exp_q.size(), 32'd0);

    // ---- zero substitution and LOAD addresses
    repeat (20) tick();
    mem_a[1] = 8'h00;
    rx_log_a.delete();
    load_addr_q.delete();
    last_load_addr = 9'h1FF;
    send_a();
    wait_done_a(1'b0, lat);
    check("done_latency_2", lat, 32'd1620);
    check("zero_as_space", {24'd0, (rx_log_a.size() > 1) ? rx_log_a[1] : 8'hFF}, 32'h20);
    check("load_addr_count", load_addr_q.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("load_addr%0d", i),
            {23'd0, (load_addr_q.size() > i) ? load_addr_q[i] : 9'h1FF}, {23'd0, exp_addr[i]});
    end
    mem_a[1] = 8'h42;

    // ---- start pulses while busy (mid-data and in the done cycle)
    repeat (20) tick();
    rx0 = rx_cnt_a; dn0 = done_cnt_a;
    send_a();
    repeat (40) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a(1'b1, lat);
    check("done_latency_3", lat, 32'd1620);
    repeat (400) tick();
    check("no_restart_state", {29'd0, st_a}, 32'd0);
    check("no_restart_busy", {31'd0, busy_a}, 32'd0);
    check("rx_count_3", rx_cnt_a - rx0, 32'd10);
    check("done_count_3", done_cnt_a - dn0, 32'd1);
    check("exp_q_empty_3", exp_q.size(), 32'd0);

    // ---- reset during the third data bit of byte 2
    rx0 = rx_cnt_a; dn0 = done_cnt_a;
    send_a();
    repeat (218) tick();
    #2;
    mon_abort = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_mid_tx", {31'd0, tx_a}, 32'd1);
    check("rst_mid_busy", {31'd0, busy_a}, 32'd0);
    check("rst_mid_re", {31'd0, re_a}, 32'd0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (300) tick();
    check("rst_no_done", done_cnt_a - dn0, 32'd0);
    check("rst_rx_count", rx_cnt_a - rx0, 32'd1);
    check("rst_line_idle", {31'd0, tx_a}, 32'd1);
    rx0 = rx_cnt_a; dn0 = done_cnt_a;
    load_addr_q.delete();
    last_load_addr = 9'h1FF;
    send_a();
    wait_done_a(1'b0, lat);
    check("done_latency_4", lat, 32'd1620);
    tick();
    check("rx_count_4", rx_cnt_a - rx0, 32'd10);
    check("done_count_4", done_cnt_a - dn0, 32'd1);
    check("first_load_addr_4", {23'd0, (load_addr_q.size() > 0) ? load_addr_q[0] : 9'h1FF}, 32'd0);
    check("exp_q_empty_4", exp_q.size(), 32'd0);

    // ---- full-size document on instance b
    check("idle_before_b", {31'd0, tx_b}, 32'd1);
    for (int r = 0; r < ROWS_B; r++) begin
      for (int c = 0; c < COLS_B; c++) begin
        exp_qb.push_back((mem_b[r * 32 + c] == 8'h00) ? 8'h20 : mem_b[r * 32 + c]);
      end
      exp_qb.push_back(8'h0D);
      exp_qb.push_back(8'h0A);
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    s_cyc = cyc;
    lat = -1;
    for (int k = 0; k < 20000; k++) begin
      if (done_b === 1'b1) begin
        lat = cyc - s_cyc;
        break;
      end
      tick();
    end
    check("done_latency_b", lat, 32'd13860);
    check("busy_at_done_b", {31'd0, busy_b}, 32'd1);
    tick();
    check("done_low_after_b", {31'd0, done_b}, 32'd0);
    check("busy_low_after_b", {31'd0, busy_b}, 32'd0);
    repeat (50) tick();
    check("rx_count_b", rx_cnt_b, 32'd330);
    check("done_count_b", done_cnt_b, 32'd1);
    check("exp_qb_empty", exp_qb.size(), 32'd0);
    check("idle_after_b", {31'd0, tx_b}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/doc_uart_sender.md
Name: doc_uart_sender

Overview:
- Serialises the document RAM over UART 8N1 when the user requests a send.
- Sits between text_editor/document and the board TX pin. Drives the document read port: text_editor's read_enable/read_out_addr. Receives read data from document spo.
- Pulses done into text_editor clear_data once the last byte leaves.
- Output stream is row-major text: COLS characters per row, then CR LF, for ROWS rows.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD clocks per bit (integer division, 868 at defaults).
- ROWS, 15, document rows sent (1..16).
- COLS, 20, characters per row sent (1..32).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request, already debounced and one-pulsed upstream.
- read_enable  out  1  claims the document read port.
- read_addr  out  9  document address {row[3:0], col[4:0]}.
- read_data  in  8  document spo; combinational read of read_addr.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high from accepted start through the done cycle.
- done  out  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset (async, immediate) values: tx=1, busy=0, done=0, read_enable=0, read_addr=0. FSM goes to IDLE; counters clear.
- FSM states: IDLE, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT, DONE.
- IDLE:
  - start=1 -> LOAD, row=0, col=0, sel=CHAR.
  - busy and read_enable rise in the same edge.
  - start is ignored in every state other than IDLE.
- LOAD (1 cycle): read_addr={row,col}. Latch the shift byte at the end of the cycle:
  - sel=CHAR: read_data, except 0x00 is sent as 0x20.
  - sel=CR: 0x0D.
  - sel=LF: 0x0A.
- START_BIT: tx=0 for DIV clocks.
- DATA_BITS: 8 bits, LSB first, each bit held exactly DIV clocks.
- STOP_BIT: tx=1 for DIV clocks, then NEXT.
- Bit timer: counts 0..DIV-1, reloads at each bit boundary. Byte period = 10*DIV clocks + LOAD + NEXT overhead (2 clocks).
- NEXT (1 cycle), advance:
  - sel=CHAR, col<COLS-1: col+1.
  - sel=CHAR, col=COLS-1: sel=CR.
  - sel=CR: sel=LF.
  - sel=LF, row<ROWS-1: row+1, col=0, sel=CHAR.
  - sel=LF, row=ROWS-1: DONE. Every other case: LOAD.
- DONE (1 cycle): done=1, busy=1, read_enable=1. Next cycle: IDLE, all three low.
- Total bytes per send: ROWS*(COLS+2); 330 at defaults.
- read_addr is {row,col} whenever read_enable=1. It only changes in NEXT, so it is stable during each LOAD.
- tx is registered (glitch-free). tx=1 in IDLE, LOAD, NEXT and DONE.
- Reset mid-byte: tx returns high immediately, with no further output. The partial frame is abandoned and done does not pulse.
- start coinciding with the done cycle is ignored. A new send needs a fresh pulse once in IDLE.

Test Plan:
- Sim params CLK_HZ=16, BAUD=1 (DIV=16), ROWS=2, COLS=3; document preloaded addr0..2="ABC", addr32..34="xyz"; start pulse -> tx decodes exactly 0x41 0x42 0x43 0x0D 0x0A 0x78 0x79 0x7A 0x0D 0x0A. done pulses once, 1 cycle, after the 10th stop bit; busy drops the next cycle.
- Bit timing: measure the first frame -> start bit low exactly 16 clocks; each data bit 16 clocks; LSB first (0x41 gives 1,0,0,0,0,0,1,0); stop high 16 clocks.
- Zero substitution: addr1=0x00 -> second byte received is 0x20. read_addr seen at each LOAD = 0,1,2,32,33,34 in order.
- start pulses while busy (mid-data and during DONE) -> byte stream and done timing identical to the first test; no second transfer starts.
- Assert rst during the 3rd data bit of byte 2 -> tx=1, busy=0, read_enable=0 within the same cycle; no done pulse. A later start sends the full sequence from addr 0.
- Default params: one send -> exactly 330 frames; done asserted 1 cycle; line idle high before and after.
